// File: rtl/amo_unit.sv
// Atomic-memory-operation unit: passes ordinary loads/stores straight to the
// membus and expands RV64A LR/SC/AMO requests into read-modify-write sequences.
module amo_unit #(
  parameter int XLEN       = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    slave_valid,
  output logic                    slave_ready,
  input  logic [XLEN-1:0]         slave_addr,
  input  logic                    slave_wen,
  input  logic [DATA_WIDTH-1:0]   slave_wdata,
  input  logic [DATA_WIDTH/8-1:0] slave_wmask,
  input  logic                    slave_is_amo,
  input  logic [4:0]              slave_amoop,
  input  logic [2:0]              slave_funct3,
  output logic                    slave_rvalid,
  output logic [DATA_WIDTH-1:0]   slave_rdata,

  output logic                    master_valid,
  input  logic                    master_ready,
  output logic [XLEN-1:0]         master_addr,
  output logic                    master_wen,
  output logic [DATA_WIDTH-1:0]   master_wdata,
  output logic [DATA_WIDTH/8-1:0] master_wmask,
  input  logic                    master_rvalid,
  input  logic [DATA_WIDTH-1:0]   master_rdata
);

  localparam int MW = DATA_WIDTH / 8;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    IDLE,
    AMO_RD,
    AMO_RD_WAIT,
    AMO_WR,
    AMO_WR_WAIT,
    SC_FAIL
  } state_t;

  state_t                  state_q, state_d;
  logic                    pending_q;
  logic [XLEN-1:0]         addr_q;
  logic [4:0]              op_q;
  logic                    is_w_q;
  logic [DATA_WIDTH-1:0]   opnd_q;
  logic [DATA_WIDTH-1:0]   old_q;
  logic [DATA_WIDTH-1:0]   wr_q;
  logic                    resv_v_q;
  logic [XLEN-1:0]         resv_a_q;

  logic                    pt_ok;
  logic                    pt_fire;
  logic                    amo_acc;
  logic                    sc_ok;
  logic                    is_w_in;
  logic [31:0]             ld_word;
  logic [DATA_WIDTH-1:0]   ld_val;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH-1:0]   sc_wdata;
  logic [MW-1:0]           amo_mask;

  assign is_w_in  = (slave_funct3 == 3'b010);
  assign pt_ok    = !pending_q || master_rvalid;
  assign pt_fire  = !rst && (state_q == IDLE) && slave_valid && !slave_is_amo &&
                    master_ready && pt_ok;
  assign amo_acc  = !rst && (state_q == IDLE) && slave_valid && slave_is_amo && !pending_q;
  assign sc_ok    = resv_v_q && (resv_a_q == slave_addr);
  assign sc_wdata = is_w_in ? {slave_wdata[31:0], slave_wdata[31:0]} : slave_wdata;

  assign ld_word  = addr_q[2] ? master_rdata[63:32] : master_rdata[31:0];
  assign ld_val   = is_w_q ? {{(DATA_WIDTH-32){ld_word[31]}}, ld_word} : master_rdata;
  assign amo_mask = is_w_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;

  // Both widths are computed; a W result is replicated so it lands in either half.
  always_comb begin
    logic [DATA_WIDTH-1:0] a64, b64, r64;
    logic [31:0]           a32, b32, r32;
    a64 = ld_val;
    b64 = opnd_q;
    a32 = ld_val[31:0];
    b32 = opnd_q[31:0];
    r64 = '0;
    r32 = '0;
    case (op_q)
      OP_ADD:  begin r64 = a64 + b64; r32 = a32 + b32; end
      OP_SWAP: begin r64 = b64;       r32 = b32;       end
      OP_XOR:  begin r64 = a64 ^ b64; r32 = a32 ^ b32; end
      OP_OR:   begin r64 = a64 | b64; r32 = a32 | b32; end
      OP_AND:  begin r64 = a64 & b64; r32 = a32 & b32; end
      OP_MIN:  begin
        r64 = ($signed(a64) < $signed(b64)) ? a64 : b64;
        r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
      end
      OP_MAX:  begin
        r64 = ($signed(a64) > $signed(b64)) ? a64 : b64;
        r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
      end
      OP_MINU: begin
        r64 = (a64 < b64) ? a64 : b64;
        r32 = (a32 < b32) ? a32 : b32;
      end
      OP_MAXU: begin
        r64 = (a64 > b64) ? a64 : b64;
        r32 = (a32 > b32) ? a32 : b32;
      end
      default: begin r64 = b64; r32 = b32; end
    endcase
    alu_res = is_w_q ? {r32, r32} : r64;
  end

  always_comb begin
    state_d      = state_q;
    slave_ready  = 1'b0;
    slave_rvalid = 1'b0;
    slave_rdata  = master_rdata;
    master_valid = 1'b0;
    master_addr  = addr_q;
    master_wen   = 1'b0;
    master_wdata = wr_q;
    master_wmask = amo_mask;
    case (state_q)
      IDLE: begin
        master_addr  = slave_addr;
        master_wen   = slave_wen;
        master_wdata = slave_wdata;
        master_wmask = slave_wmask;
        slave_rvalid = pending_q && master_rvalid;
        if (slave_is_amo) begin
          slave_ready = !pending_q;
          if (slave_valid && !pending_q) begin
            if (slave_amoop == OP_SC) state_d = sc_ok ? AMO_WR : SC_FAIL;
            else                      state_d = AMO_RD;
          end
        end else begin
          master_valid = slave_valid && pt_ok;
          slave_ready  = master_ready && pt_ok;
        end
      end
      AMO_RD: begin
        master_valid = 1'b1;
        if (master_ready) state_d = AMO_RD_WAIT;
      end
      AMO_RD_WAIT: begin
        if (master_rvalid) begin
          if (op_q == OP_LR) begin
            slave_rvalid = 1'b1;
            slave_rdata  = ld_val;
            state_d      = IDLE;
          end else begin
            state_d = AMO_WR;
          end
        end
      end
      AMO_WR: begin
        master_valid = 1'b1;
        master_wen   = 1'b1;
        if (master_ready) state_d = AMO_WR_WAIT;
      end
      AMO_WR_WAIT: begin
        if (master_rvalid) begin
          slave_rvalid = 1'b1;
          slave_rdata  = (op_q == OP_SC) ? '0 : old_q;
          state_d      = IDLE;
        end
      end
      SC_FAIL: begin
        slave_rvalid   = 1'b1;
        slave_rdata    = '0;
        slave_rdata[0] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      slave_ready  = 1'b0;
      master_valid = 1'b0;
      slave_rvalid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      addr_q    <= '0;
      op_q      <= '0;
      is_w_q    <= 1'b0;
      opnd_q    <= '0;
      old_q     <= '0;
      wr_q      <= '0;
      resv_v_q  <= 1'b0;
      resv_a_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pt_fire)            pending_q <= 1'b1;
      else if (master_rvalid) pending_q <= 1'b0;
      if (amo_acc) begin
        addr_q <= slave_addr;
        op_q   <= slave_amoop;
        is_w_q <= is_w_in;
        opnd_q <= slave_wdata;
        if (slave_amoop == OP_SC) begin
          wr_q     <= sc_wdata;
          resv_v_q <= 1'b0;
        end
      end
      if ((state_q == AMO_RD_WAIT) && master_rvalid) begin
        if (op_q == OP_LR) begin
          resv_v_q <= 1'b1;
          resv_a_q <= addr_q;
        end else begin
          old_q <= ld_val;
          wr_q  <= alu_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_amo_unit.sv
// Self-checking bench for amo_unit: directed scenarios plus randomized traffic
// checked against a word-level memory/reservation reference model.
module tb_amo_unit;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_valid = 1'b0;
  logic        slave_ready;
  logic [63:0] slave_addr = '0;
  logic        slave_wen = 1'b0;
  logic [63:0] slave_wdata = '0;
  logic [7:0]  slave_wmask = '0;
  logic        slave_is_amo = 1'b0;
  logic [4:0]  slave_amoop = '0;
  logic [2:0]  slave_funct3 = 3'b011;
  logic        slave_rvalid;
  logic [63:0] slave_rdata;
  logic        master_valid;
  logic        master_ready = 1'b1;
  logic [63:0] master_addr;
  logic        master_wen;
  logic [63:0] master_wdata;
  logic [7:0]  master_wmask;
  logic        master_rvalid = 1'b0;
  logic [63:0] master_rdata = '0;

  amo_unit #(.XLEN(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .slave_valid(slave_valid), .slave_ready(slave_ready), .slave_addr(slave_addr),
    .slave_wen(slave_wen), .slave_wdata(slave_wdata), .slave_wmask(slave_wmask),
    .slave_is_amo(slave_is_amo), .slave_amoop(slave_amoop), .slave_funct3(slave_funct3),
    .slave_rvalid(slave_rvalid), .slave_rdata(slave_rdata),
    .master_valid(master_valid), .master_ready(master_ready), .master_addr(master_addr),
    .master_wen(master_wen), .master_wdata(master_wdata), .master_wmask(master_wmask),
    .master_rvalid(master_rvalid), .master_rdata(master_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory behind the membus and the reference model's view of it.
  logic [63:0] mem     [logic [60:0]];
  logic [63:0] ref_mem [logic [60:0]];
  logic        ref_resv_v = 1'b0;
  logic [63:0] ref_resv_a = '0;

  function automatic logic [63:0] mem_rd(input logic [60:0] i);
    return mem.exists(i) ? mem[i] : 64'h0;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [60:0] i);
    return ref_mem.exists(i) ? ref_mem[i] : 64'h0;
  endfunction

  task automatic set_mem(input logic [63:0] a, input logic [63:0] v);
    mem[a[63:3]]     = v;
    ref_mem[a[63:3]] = v;
  endtask

  // Membus responder: one-cycle latency, optional random or forced back-pressure.
  logic        acc_q = 1'b0;
  logic [63:0] req_addr, req_wdata;
  logic        req_wen;
  logic [7:0]  req_wmask;
  int          acc_cnt = 0;
  int          rv_cnt = 0;
  bit          rand_ready = 1'b0;
  int          stall_wr = 0;
  bit          stall_first = 1'b0;
  logic [63:0] st_addr, st_wdata;
  logic [7:0]  st_mask;
  logic [63:0] last_wr_data = '0;
  logic [7:0]  last_wr_mask = '0;

  always @(negedge clk) begin
    logic [63:0] w;
    if (acc_q) begin
      master_rvalid = 1'b1;
      if (req_wen) begin
        w = mem_rd(req_addr[63:3]);
        for (int b = 0; b < 8; b++)
          if (req_wmask[b]) w[b*8 +: 8] = req_wdata[b*8 +: 8];
        mem[req_addr[63:3]] = w;
        master_rdata = '0;
        last_wr_data = req_wdata;
        last_wr_mask = req_wmask;
      end else begin
        master_rdata = mem_rd(req_addr[63:3]);
      end
    end else begin
      master_rvalid = 1'b0;
      master_rdata  = {$urandom, $urandom};
    end
    acc_q = 1'b0;
    #1;
    if (stall_wr > 0 && master_valid && master_wen) begin
      master_ready = 1'b0;
      if (stall_first) begin
        st_addr = master_addr; st_wdata = master_wdata; st_mask = master_wmask;
        stall_first = 1'b0;
      end else begin
        check("stall_addr", master_addr, st_addr);
        check("stall_wdata", master_wdata, st_wdata);
        check("stall_wmask", {56'h0, master_wmask}, {56'h0, st_mask});
      end
      check("stall_sready", {63'h0, slave_ready}, 64'h0);
      stall_wr--;
    end else begin
      master_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    if (master_valid && master_ready) begin
      req_addr = master_addr; req_wen = master_wen;
      req_wdata = master_wdata; req_wmask = master_wmask;
      acc_q = 1'b1;
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    #3;
    if (slave_rvalid) rv_cnt++;
  end

  function automatic logic [63:0] amo_new(input logic [4:0] op, input bit isw,
                                          input logic [63:0] oldx, input logic [63:0] wd);
    if (isw) begin
      int          x  = int'(oldx[31:0]);
      int          y  = int'(wd[31:0]);
      int unsigned ux = oldx[31:0];
      int unsigned uy = wd[31:0];
      int          r;
      case (op)
        F_ADD:  r = x + y;
        F_SWAP: r = y;
        F_XOR:  r = x ^ y;
        F_OR:   r = x | y;
        F_AND:  r = x & y;
        F_MIN:  r = (x < y) ? x : y;
        F_MAX:  r = (x > y) ? x : y;
        F_MINU: r = int'((ux < uy) ? ux : uy);
        default: r = int'((ux > uy) ? ux : uy);
      endcase
      return {32'h0, r};
    end else begin
      longint          x  = longint'(oldx);
      longint          y  = longint'(wd);
      longint unsigned ux = oldx;
      longint unsigned uy = wd;
      longint          r;
      case (op)
        F_ADD:  r = x + y;
        F_SWAP: r = y;
        F_XOR:  r = x ^ y;
        F_OR:   r = x | y;
        F_AND:  r = x & y;
        F_MIN:  r = (x < y) ? x : y;
        F_MAX:  r = (x > y) ? x : y;
        F_MINU: r = longint'((ux < uy) ? ux : uy);
        default: r = longint'((ux > uy) ? ux : uy);
      endcase
      return r;
    end
  endfunction

  function automatic logic [63:0] place(input logic [63:0] oldw, input logic [63:0] v,
                                        input bit isw, input logic a2);
    if (!isw) return v;
    return a2 ? {v[31:0], oldw[31:0]} : {oldw[63:32], v[31:0]};
  endfunction

  // Issue one core request, predict its outcome from the model, and check it.
  task automatic do_op(input string tag, input logic [63:0] a, input logic amo,
                       input logic [4:0] op, input logic [2:0] f3, input logic wen,
                       input logic [63:0] wd, input logic [7:0] wm, input int exp_lat);
    logic [60:0] idx;
    logic [63:0] oldw, neww, oldx, rd_exp, rd_got;
    logic [31:0] w32;
    bit          isw, chk_rd, got;
    int          nacc, acc0, rv0, lat;
    idx    = a[63:3];
    oldw   = ref_rd(idx);
    neww   = oldw;
    chk_rd = 1'b1;
    isw    = (f3 == 3'b010);
    w32    = a[2] ? oldw[63:32] : oldw[31:0];
    oldx   = isw ? {{32{w32[31]}}, w32} : oldw;
    rd_exp = '0;
    if (!amo) begin
      nacc = 1;
      if (wen) begin
        for (int b = 0; b < 8; b++) if (wm[b]) neww[b*8 +: 8] = wd[b*8 +: 8];
        chk_rd = 1'b0;
      end else rd_exp = oldw;
    end else if (op == F_LR) begin
      rd_exp = oldx; nacc = 1; ref_resv_v = 1'b1; ref_resv_a = a;
    end else if (op == F_SC) begin
      if (ref_resv_v && ref_resv_a == a) begin
        neww = place(oldw, wd, isw, a[2]); rd_exp = 64'h0; nacc = 1;
      end else begin
        rd_exp = 64'h1; nacc = 0;
      end
      ref_resv_v = 1'b0;
    end else begin
      neww = place(oldw, amo_new(op, isw, oldx, wd), isw, a[2]);
      rd_exp = oldx; nacc = 2;
    end
    ref_mem[idx] = neww;

    acc0 = acc_cnt;
    rv0  = rv_cnt;
    @(negedge clk);
    slave_valid = 1'b1; slave_addr = a; slave_is_amo = amo; slave_amoop = op;
    slave_funct3 = f3; slave_wen = wen; slave_wdata = wd; slave_wmask = wm;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (slave_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_accept"}, {63'h0, got}, 64'h1);
    if (got) begin
      if (!amo) begin
        check({tag, "_pt_mvalid"}, {63'h0, master_valid}, 64'h1);
        check({tag, "_pt_addr"}, master_addr, a);
        check({tag, "_pt_wen"}, {63'h0, master_wen}, {63'h0, wen});
        check({tag, "_pt_wdata"}, master_wdata, wd);
        check({tag, "_pt_wmask"}, {56'h0, master_wmask}, {56'h0, wm});
      end else begin
        check({tag, "_acc_mvalid"}, {63'h0, master_valid}, 64'h0);
      end
    end
    got = 1'b0; lat = 0; rd_got = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) slave_valid = 1'b0;
      #3;
      if (slave_rvalid) begin got = 1'b1; lat = c; rd_got = slave_rdata; break; end
    end
    slave_valid = 1'b0;
    check({tag, "_resp"}, {63'h0, got}, 64'h1);
    if (got && chk_rd) check({tag, "_rdata"}, rd_got, rd_exp);
    if (got && exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    #4;
    check({tag, "_rvalid_cnt"}, 64'(rv_cnt - rv0), 64'h1);
    check({tag, "_bus_cnt"}, 64'(acc_cnt - acc0), 64'(nacc));
    check({tag, "_mem"}, mem_rd(idx), neww);
  endtask

  logic [4:0] amo_ops [11] = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                                F_MIN, F_MAX, F_MINU, F_MAXU};

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, rv0;
    // Reset: outputs quiet even with a request pending on the core side.
    slave_valid = 1'b1;
    #2;
    check("rst_sready", {63'h0, slave_ready}, 64'h0);
    check("rst_mvalid", {63'h0, master_valid}, 64'h0);
    check("rst_rvalid", {63'h0, slave_rvalid}, 64'h0);
    repeat (3) @(negedge clk);
    slave_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    set_mem(64'h8000_0010, 64'h1122334455667788);
    do_op("pt_ld", 64'h8000_0010, 1'b0, 5'h0, 3'b011, 1'b0, 64'h0, 8'h00, 1);

    set_mem(64'h100, 64'd5);
    do_op("amoadd_d", 64'h100, 1'b1, F_ADD, 3'b011, 1'b0, 64'd7, 8'h00, 4);
    check("amoadd_d_wdata", last_wr_data, 64'd12);
    check("amoadd_d_wmask", {56'h0, last_wr_mask}, 64'hFF);

    set_mem(64'h100, 64'h0000_0001_1234_5678);
    do_op("amomin_w", 64'h104, 1'b1, F_MIN, 3'b010, 1'b0, 64'hFFFF_FFFF, 8'h00, 4);
    check("amomin_w_wdata_hi", {32'h0, last_wr_data[63:32]}, 64'hFFFF_FFFF);
    check("amomin_w_wmask", {56'h0, last_wr_mask}, 64'hF0);

    set_mem(64'h200, 64'h0);
    do_op("lr_d", 64'h200, 1'b1, F_LR, 3'b011, 1'b0, 64'h0, 8'h00, 2);
    do_op("sc_d_ok", 64'h200, 1'b1, F_SC, 3'b011, 1'b0, 64'hAB, 8'h00, 2);
    do_op("sc_d_again", 64'h200, 1'b1, F_SC, 3'b011, 1'b0, 64'hCD, 8'h00, 1);

    set_mem(64'h100, 64'h0000_0000_8000_0000);
    do_op("amomaxu_w", 64'h100, 1'b1, F_MAXU, 3'b010, 1'b0, 64'h1, 8'h00, 4);

    // Store to the reserved address leaves the reservation intact.
    set_mem(64'h208, 64'h77);
    do_op("lr_keep", 64'h208, 1'b1, F_LR, 3'b011, 1'b0, 64'h0, 8'h00, 2);
    do_op("st_resv", 64'h208, 1'b0, 5'h0, 3'b011, 1'b1, 64'h1234, 8'h0F, 1);
    do_op("sc_keep", 64'h208, 1'b1, F_SC, 3'b011, 1'b0, 64'h99, 8'h00, 2);
    do_op("lr_w", 64'h20C, 1'b1, F_LR, 3'b010, 1'b0, 64'h0, 8'h00, 2);
    do_op("sc_w_miss", 64'h208, 1'b1, F_SC, 3'b010, 1'b0, 64'h5, 8'h00, 1);

    // Back-pressure during the write phase.
    set_mem(64'h108, 64'hDEAD_BEEF_0000_0001);
    stall_first = 1'b1;
    stall_wr = 3;
    do_op("stall_swap", 64'h108, 1'b1, F_SWAP, 3'b011, 1'b0, 64'h0F0F, 8'h00, 7);
    check("stall_used", 64'(stall_wr), 64'h0);

    // Reset while waiting for the read data.
    set_mem(64'h300, 64'h55);
    do_op("lr_pre_rst", 64'h300, 1'b1, F_LR, 3'b011, 1'b0, 64'h0, 8'h00, 2);
    acc0 = acc_cnt;
    @(negedge clk);
    slave_valid = 1'b1; slave_is_amo = 1'b1; slave_amoop = F_ADD;
    slave_funct3 = 3'b011; slave_addr = 64'h300; slave_wdata = 64'h1; slave_wen = 1'b0;
    #3;
    check("rstmid_accept", {63'h0, slave_ready}, 64'h1);
    @(negedge clk);
    slave_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rv0 = rv_cnt;
    slave_valid = 1'b1; slave_is_amo = 1'b0;
    check("rstmid_read_issued", 64'(acc_cnt - acc0), 64'h1);
    #3;
    check("rstmid_rvalid", {63'h0, slave_rvalid}, 64'h0);
    check("rstmid_sready", {63'h0, slave_ready}, 64'h0);
    check("rstmid_mvalid", {63'h0, master_valid}, 64'h0);
    ref_resv_v = 1'b0;
    repeat (2) @(negedge clk);
    slave_valid = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #4;
    check("rstmid_no_resp", 64'(rv_cnt - rv0), 64'h0);
    do_op("sc_after_rst", 64'h300, 1'b1, F_SC, 3'b011, 1'b0, 64'h3, 8'h00, 1);

    // Randomized traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) set_mem(64'h100 + 64'(i * 8), {$urandom, $urandom});
    for (int i = 0; i < 200; i++) begin
      logic [63:0] a;
      logic [2:0]  f3;
      logic [4:0]  op;
      int          k;
      a  = 64'h100 + 64'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 64'h40;
      k  = $urandom_range(0, 13);
      op = (k < 11) ? amo_ops[k] : F_ADD;
      if (op == F_SC && ref_resv_v && $urandom_range(0, 1) == 1) a = ref_resv_a;
      f3 = (a[2] || $urandom_range(0, 1) == 0) ? 3'b010 : 3'b011;
      if (k >= 11)
        do_op("rnd_pt", a & ~64'h7, 1'b0, 5'h0, 3'b011, ($urandom_range(0, 1) == 1),
              {$urandom, $urandom}, 8'($urandom), 0);
      else
        do_op("rnd_amo", a, 1'b1, op, f3, 1'b0, {$urandom, $urandom}, 8'h00, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
